// File: rtl/led_status_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_status_pkg
//  Description : Shared types and LED patterns for the self-destruct status
//                display: display state enum, fixed LED patterns and the
//                count-to-state decode used outside the lamp test.
//  Revision    : 1.0  initial release
// ============================================================================
package led_status_pkg;

  typedef enum logic [1:0] {
    LAMP_TEST = 2'd0,
    IDLE      = 2'd1,
    COUNT     = 2'd2,
    DETONATED = 2'd3
  } led_state_e;

  localparam logic [3:0] PAT_ALL   = 4'hF;
  localparam logic [3:0] PAT_OFF   = 4'h0;
  localparam logic [3:0] PAT_DET_A = 4'hA;
  localparam logic [3:0] PAT_DET_B = 4'h5;

  // Plain (non-sticky) decode of a count value; callers add DETONATED stickiness.
  // cnt_max is 5 bits so that a threshold of 16 (never detonate) is expressible.
  function automatic led_state_e decode_count(input logic [3:0] cnt,
                                              input logic [4:0] cnt_max);
    if ({1'b0, cnt} >= cnt_max) begin
      return DETONATED;
    end else if (cnt == 4'd0) begin
      return IDLE;
    end else begin
      return COUNT;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divide-by-DIV counter producing a registered
//                one-cycle tick strobe once every DIV clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
  parameter int DIV = 60001
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] count_q;
  logic         tick_q;

  // Wrap the divider at DIV-1 and register the strobe so tick is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      if (count_q == LAST) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
      tick_q <= (count_q == LAST);
    end
  end

  assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/led_status_driver.sv
`default_nettype none
// ============================================================================
//  Module      : led_status_driver
//  Description : Drives the 4 board LEDs from the countdown value: lamp test
//                after reset, idle, blinking count (fast near the end) and an
//                alternating detonation flash. Timing comes from an internal
//                tick prescaler; all tick-count parameters must be 1..255.
//  Revision    : 1.0  initial release
// ============================================================================
module led_status_driver
  import led_status_pkg::*;
#(
  parameter int TICK_DIV   = 60001,
  parameter int CNT_MAX    = 10,
  parameter int WARN_AT    = 7,
  parameter int LAMP_TICKS = 100,
  parameter int BLINK_SLOW = 50,
  parameter int BLINK_FAST = 10,
  parameter int FLASH      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cnt_in,
  output logic [3:0] LEDs,
  output logic       detonated
);

  localparam logic [4:0] CNT_MAX_W = 5'(CNT_MAX);
  localparam logic [4:0] WARN_W    = 5'(WARN_AT);
  localparam logic [7:0] LAMP_HP   = 8'(LAMP_TICKS);
  localparam logic [7:0] LAMP_LAST = 8'(LAMP_TICKS - 1);
  localparam logic [7:0] SLOW_HP   = 8'(BLINK_SLOW);
  localparam logic [7:0] FAST_HP   = 8'(BLINK_FAST);
  localparam logic [7:0] FLASH_HP  = 8'(FLASH);

  logic        w_tick;

  // Input register and the value it held on the previous clock, used to
  // detect a change of the displayed count.
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_seen_q;

  led_state_e  state_q, state_d;
  led_state_e  w_decoded;
  logic [7:0]  hp_q, hp_d;
  logic [7:0]  blink_q, blink_d;
  logic        phase_q, phase_d;
  logic [3:0]  leds_q, leds_d;
  logic        det_q, det_d;
  logic        w_restart;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Register the countdown input and remember the previous registered value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      cnt_seen_q <= 4'd0;
    end else begin
      cnt_q      <= cnt_in;
      cnt_seen_q <= cnt_q;
    end
  end

  // Next state, half-period, blink counter/phase and LED pattern.
  // Outputs are decoded from the next state so cnt_in reaches LEDs in 2 clk.
  always_comb begin
    w_decoded = decode_count(cnt_q, CNT_MAX_W);

    state_d = state_q;
    case (state_q)
      LAMP_TEST: begin
        // The blink counter doubles as the lamp-test tick counter.
        if (w_tick && (blink_q == LAMP_LAST)) begin
          state_d = w_decoded;
        end
      end
      DETONATED: begin
        // Sticky: only a zero count disarms the display.
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = w_decoded;
      end
    endcase

    case (state_d)
      LAMP_TEST: hp_d = LAMP_HP;
      COUNT:     hp_d = ({1'b0, cnt_q} < WARN_W) ? SLOW_HP : FAST_HP;
      DETONATED: hp_d = FLASH_HP;
      default:   hp_d = SLOW_HP;
    endcase

    // Count changes are meaningless during lamp test, so they only restart
    // the phase once the display is showing the count.
    w_restart = (state_d != state_q) ||
                ((state_d != LAMP_TEST) && (cnt_q != cnt_seen_q)) ||
                (hp_d != hp_q);

    blink_d = blink_q;
    phase_d = phase_q;
    if (w_restart) begin
      // Restart wins over a tick landing in the same cycle.
      blink_d = 8'd0;
      phase_d = 1'b1;
    end else if (w_tick) begin
      if (blink_q == (hp_d - 8'd1)) begin
        blink_d = 8'd0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 8'd1;
      end
    end

    case (state_d)
      LAMP_TEST: leds_d = PAT_ALL;
      COUNT:     leds_d = phase_d ? cnt_q : PAT_OFF;
      DETONATED: leds_d = phase_d ? PAT_DET_A : PAT_DET_B;
      default:   leds_d = PAT_OFF;
    endcase

    det_d = (state_d == DETONATED);
  end

  // State, blink timing and registered LED/detonated outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LAMP_TEST;
      hp_q    <= LAMP_HP;
      blink_q <= 8'd0;
      phase_q <= 1'b1;
      leds_q  <= PAT_OFF;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      leds_q  <= leds_d;
      det_q   <= det_d;
    end
  end

  assign LEDs      = leds_q;
  assign detonated = det_q;

endmodule
`default_nettype wire

// File: tb/tb_led_status_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_status_driver
//  Description : Self-checking bench for led_status_driver with small tick
//                parameters. A behavioural model tracks ticks-since-restart
//                arithmetically and predicts LEDs/detonated every clock.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_status_driver;

  localparam int TICK_DIV   = 4;
  localparam int CNT_MAX    = 10;
  localparam int WARN_AT    = 7;
  localparam int LAMP_TICKS = 2;
  localparam int BLINK_SLOW = 4;
  localparam int BLINK_FAST = 2;
  localparam int FLASH      = 1;

  // Model mode numbering: 0 lamp test, 1 idle, 2 count, 3 detonated.
  localparam int M_LAMP = 0;
  localparam int M_IDLE = 1;
  localparam int M_CNT  = 2;
  localparam int M_DET  = 3;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic [3:0] LEDs;
  logic       detonated;

  int checks = 0;
  int fails  = 0;

  int         m_mode;
  int         m_n;          // clocks since reset release
  int         m_lamp_ticks;
  int         m_tsr;        // ticks since last phase restart
  int         m_cq;         // registered count
  int         m_shown;      // count used on the previous clock
  logic [3:0] m_leds;
  logic       m_det;

  always #5 clk = ~clk;

  led_status_driver #(
    .TICK_DIV   (TICK_DIV),
    .CNT_MAX    (CNT_MAX),
    .WARN_AT    (WARN_AT),
    .LAMP_TICKS (LAMP_TICKS),
    .BLINK_SLOW (BLINK_SLOW),
    .BLINK_FAST (BLINK_FAST),
    .FLASH      (FLASH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .LEDs      (LEDs),
    .detonated (detonated)
  );

  function automatic int decode(int c);
    if (c >= CNT_MAX) return M_DET;
    if (c == 0) return M_IDLE;
    return M_CNT;
  endfunction

  function automatic int half_period(int mode, int c);
    if (mode == M_DET) return FLASH;
    if (c < WARN_AT) return BLINK_SLOW;
    return BLINK_FAST;
  endfunction

  // Advance the reference model by one clock edge with the pre-edge inputs.
  function automatic void model_edge(logic rst, logic [3:0] cin);
    int  used;
    int  nm;
    bit  tk;
    bit  on;
    if (rst) begin
      m_mode = M_LAMP; m_n = 0; m_lamp_ticks = 0; m_tsr = 0;
      m_cq = 0; m_shown = 0; m_leds = 4'h0; m_det = 1'b0;
      return;
    end
    tk   = (m_n > 0) && ((m_n % TICK_DIV) == 0);
    m_n  = m_n + 1;
    used = m_cq;
    m_cq = int'(cin);
    if (m_mode == M_LAMP) begin
      if (tk) m_lamp_ticks = m_lamp_ticks + 1;
      if (m_lamp_ticks == LAMP_TICKS) begin
        m_mode = decode(used);
        m_tsr  = 0;
      end
    end else begin
      nm = ((m_mode == M_DET) && (used != 0)) ? M_DET : decode(used);
      if ((nm != m_mode) || (used != m_shown)) m_tsr = 0;
      else if (tk) m_tsr = m_tsr + 1;
      m_mode = nm;
    end
    m_shown = used;
    on = ((m_tsr / half_period(m_mode, used)) % 2) == 0;
    case (m_mode)
      M_LAMP:  m_leds = 4'hF;
      M_CNT:   m_leds = on ? 4'(used) : 4'h0;
      M_DET:   m_leds = on ? 4'hA : 4'h5;
      default: m_leds = 4'h0;
    endcase
    m_det = (m_mode == M_DET);
  endfunction

  task automatic clk_step();
    @(posedge clk);
    model_edge(reset, cnt_in);
    #1;
  endtask

  task automatic test_reset();
    int f_run;
    reset  = 1'b1;
    cnt_in = 4'd0;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      checks++;
      if (LEDs !== 4'h0 || detonated !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: LEDs=%h det=%b want LEDs=0 det=0", LEDs, detonated);
      end
    end
    reset = 1'b0;
    f_run = 0;
    for (int i = 0; i < 12; i++) begin
      clk_step();
      if (LEDs === 4'hF) f_run++;
      checks++;
      if (LEDs !== m_leds || detonated !== m_det) begin
        fails++;
        $display("FAIL lamp_model: cyc=%0d LEDs=%h det=%b want %h/%b", i, LEDs, detonated, m_leds, m_det);
      end
    end
    checks++;
    if (f_run !== 8) begin
      fails++;
      $display("FAIL lamp_length: got %0d clk of F want 8", f_run);
    end
    checks++;
    if (LEDs !== 4'h0 || detonated !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_lamp: LEDs=%h det=%b want 0/0", LEDs, detonated);
    end
  endtask

  task automatic test_count_blink();
    cnt_in = 4'd3;
    clk_step();
    checks++;
    if (LEDs !== 4'h0) begin
      fails++;
      $display("FAIL count_latency1: LEDs=%h want 0", LEDs);
    end
    clk_step();
    checks++;
    if (LEDs !== 4'h3 || detonated !== 1'b0) begin
      fails++;
      $display("FAIL count_latency2: LEDs=%h det=%b want 3/0", LEDs, detonated);
    end
    for (int i = 0; i < 40; i++) begin
      clk_step();
      checks++;
      if (LEDs !== m_leds || detonated !== m_det) begin
        fails++;
        $display("FAIL slow_blink: cyc=%0d LEDs=%h det=%b want %h/%b", i, LEDs, detonated, m_leds, m_det);
      end
    end
  endtask

  task automatic test_warn_switch();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      clk_step();
      if (m_mode == M_CNT && m_leds == 4'h0) found = 1'b1;
    end
    checks++;
    if (!found || LEDs !== 4'h0) begin
      fails++;
      $display("FAIL off_phase_wait: found=%0d LEDs=%h want off phase", found, LEDs);
    end
    cnt_in = 4'd8;
    clk_step();
    clk_step();
    checks++;
    if (LEDs !== 4'h8) begin
      fails++;
      $display("FAIL warn_restart: LEDs=%h want 8", LEDs);
    end
    for (int i = 0; i < 24; i++) begin
      clk_step();
      checks++;
      if (LEDs !== m_leds || detonated !== m_det) begin
        fails++;
        $display("FAIL fast_blink: cyc=%0d LEDs=%h det=%b want %h/%b", i, LEDs, detonated, m_leds, m_det);
      end
    end
  endtask

  task automatic test_detonate();
    cnt_in = 4'd10;
    clk_step();
    clk_step();
    checks++;
    if (LEDs !== 4'hA || detonated !== 1'b1) begin
      fails++;
      $display("FAIL det_entry: LEDs=%h det=%b want A/1", LEDs, detonated);
    end
    for (int i = 0; i < 16; i++) begin
      clk_step();
      checks++;
      if (LEDs !== m_leds || detonated !== m_det) begin
        fails++;
        $display("FAIL det_flash: cyc=%0d LEDs=%h det=%b want %h/%b", i, LEDs, detonated, m_leds, m_det);
      end
    end
    cnt_in = 4'd12;
    for (int i = 0; i < 8; i++) begin
      clk_step();
      checks++;
      if (detonated !== 1'b1 || LEDs !== m_leds) begin
        fails++;
        $display("FAIL det_12: cyc=%0d LEDs=%h det=%b want %h/1", i, LEDs, detonated, m_leds);
      end
    end
    cnt_in = 4'd4;
    for (int i = 0; i < 8; i++) begin
      clk_step();
      checks++;
      if (detonated !== 1'b1 || LEDs !== m_leds) begin
        fails++;
        $display("FAIL det_sticky: cyc=%0d LEDs=%h det=%b want %h/1", i, LEDs, detonated, m_leds);
      end
    end
  endtask

  task automatic test_disarm();
    cnt_in = 4'd0;
    clk_step();
    clk_step();
    checks++;
    if (LEDs !== 4'h0 || detonated !== 1'b0) begin
      fails++;
      $display("FAIL disarm: LEDs=%h det=%b want 0/0", LEDs, detonated);
    end
  endtask

  task automatic test_reset_mid();
    cnt_in = 4'd5;
    repeat (3) clk_step();
    checks++;
    if (LEDs !== 4'h5) begin
      fails++;
      $display("FAIL pre_reset_on: LEDs=%h want 5", LEDs);
    end
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    checks++;
    if (LEDs !== 4'h0 || detonated !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: LEDs=%h det=%b want 0/0", LEDs, detonated);
    end
    for (int i = 0; i < 9; i++) begin
      clk_step();
      checks++;
      if (LEDs !== ((i < 8) ? 4'hF : 4'h5)) begin
        fails++;
        $display("FAIL relamp: cyc=%0d LEDs=%h want %h", i, LEDs, (i < 8) ? 4'hF : 4'h5);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int k = 0; k < 60; k++) begin
      cnt_in = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 19) == 0) reset = 1'b1;
      hold = $urandom_range(1, 30);
      for (int i = 0; i < hold; i++) begin
        clk_step();
        reset = 1'b0;
        checks++;
        if (LEDs !== m_leds || detonated !== m_det) begin
          fails++;
          $display("FAIL random: k=%0d cyc=%0d cnt=%0d LEDs=%h det=%b want %h/%b",
                   k, i, cnt_in, LEDs, detonated, m_leds, m_det);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_blink();
    test_warn_switch();
    test_detonate();
    test_disarm();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
